// File: rtl/subservient_sram_pkg.sv
// Shared types and constants for the subservient SRAM arbiter: FSM states and
// the byte-sequencer counter limits.
package subservient_sram_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    ACK   = 2'd3
  } state_e;

  localparam int         BYTES_PER_WORD = 4;
  localparam logic [2:0] WRITE_LAST_CNT = 3'd3;
  localparam logic [2:0] READ_LAST_CNT  = 3'd4;

endpackage

// File: rtl/subservient_sram_arb.sv
// Round-robin arbiter that shares one byte-wide SRAM between two 32-bit
// Wishbone-classic masters, sequencing each word access as four byte accesses.
import subservient_sram_pkg::*;

module subservient_sram_arb #(
  parameter int memsize = 512,
  parameter int aw      = $clog2(memsize)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [31:0]   i_wb_m0_adr,
  input  logic [31:0]   i_wb_m0_dat,
  input  logic [3:0]    i_wb_m0_sel,
  input  logic          i_wb_m0_we,
  input  logic          i_wb_m0_stb,
  output logic [31:0]   o_wb_m0_rdt,
  output logic          o_wb_m0_ack,
  input  logic [31:0]   i_wb_m1_adr,
  input  logic [31:0]   i_wb_m1_dat,
  input  logic [3:0]    i_wb_m1_sel,
  input  logic          i_wb_m1_we,
  input  logic          i_wb_m1_stb,
  output logic [31:0]   o_wb_m1_rdt,
  output logic          o_wb_m1_ack,
  output logic [aw-1:0] o_sram_waddr,
  output logic [7:0]    o_sram_wdata,
  output logic          o_sram_wen,
  output logic [aw-1:0] o_sram_raddr,
  input  logic [7:0]    i_sram_rdata,
  output logic          o_busy
);

  state_e        state, state_nxt;
  logic [2:0]    cnt;
  logic          last_grant;
  logic          grant;
  logic [aw-3:0] adr_q;
  logic [31:0]   dat_q;
  logic [3:0]    sel_q;
  logic          we_q;
  logic [31:0]   rdt0_q, rdt1_q;
  logic          req_any, grant_nxt, grant_we;
  logic [1:0]    rd_lane;

  assign req_any   = i_wb_m0_stb | i_wb_m1_stb;
  // On a tie the master that was not served last wins.
  assign grant_nxt = (i_wb_m0_stb & i_wb_m1_stb) ? ~last_grant : i_wb_m1_stb;
  assign grant_we  = grant_nxt ? i_wb_m1_we : i_wb_m0_we;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // NOTE: state_nxt gets its default first so no path through the case
  // leaves it unassigned and infers a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_any) state_nxt = grant_we ? WRITE : READ;
      WRITE:   if (cnt == WRITE_LAST_CNT) state_nxt = ACK;
      READ:    if (cnt == READ_LAST_CNT) state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt        <= 3'd0;
      last_grant <= 1'b1;
      grant      <= 1'b0;
      adr_q      <= '0;
      dat_q      <= 32'h0;
      sel_q      <= 4'h0;
      we_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_any) begin
          grant      <= grant_nxt;
          last_grant <= grant_nxt;
          cnt        <= 3'd0;
          adr_q      <= grant_nxt ? i_wb_m1_adr[aw-1:2] : i_wb_m0_adr[aw-1:2];
          dat_q      <= grant_nxt ? i_wb_m1_dat : i_wb_m0_dat;
          sel_q      <= grant_nxt ? i_wb_m1_sel : i_wb_m0_sel;
          we_q       <= grant_we;
        end
        WRITE, READ: cnt <= cnt + 3'd1;
        default: ;
      endcase
    end
  end

  // Read data arrives one cycle behind its address, so count n fills lane n-1.
  assign rd_lane = cnt[1:0] - 2'd1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rdt0_q <= 32'h0;
      rdt1_q <= 32'h0;
    end else if (state == READ && cnt != 3'd0) begin
      if (grant) rdt1_q[{rd_lane, 3'b000} +: 8] <= i_sram_rdata;
      else       rdt0_q[{rd_lane, 3'b000} +: 8] <= i_sram_rdata;
    end
  end

  assign o_sram_waddr = {adr_q, cnt[1:0]};
  assign o_sram_raddr = {adr_q, cnt[1:0]};
  assign o_sram_wdata = dat_q[{cnt[1:0], 3'b000} +: 8];
  assign o_sram_wen   = (state == WRITE) & sel_q[cnt[1:0]];

  assign o_wb_m0_ack  = (state == ACK) & ~grant;
  assign o_wb_m1_ack  = (state == ACK) &  grant;
  assign o_wb_m0_rdt  = rdt0_q;
  assign o_wb_m1_rdt  = rdt1_q;
  assign o_busy       = (state != IDLE);

  // Word-aligned, aliasing address: the low two and high bits are don't-care.
  logic unused_adr_bits;
  assign unused_adr_bits = ^{i_wb_m0_adr[31:aw], i_wb_m0_adr[1:0],
                             i_wb_m1_adr[31:aw], i_wb_m1_adr[1:0], we_q};

endmodule

// File: tb/tb_subservient_sram_arb.sv
// Scoreboard bench for subservient_sram_arb: a word-level memory model predicts
// grant order, ack cycle, read data and SRAM byte writes; a monitor compares.
`timescale 1ns/1ps

module tb_subservient_sram_arb;

  localparam int MEMSIZE = 512;
  localparam int AW      = 9;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [31:0]   m0_adr, m0_dat, m1_adr, m1_dat;
  logic [3:0]    m0_sel, m1_sel;
  logic          m0_we, m0_stb, m1_we, m1_stb;
  logic [31:0]   m0_rdt, m1_rdt;
  logic          m0_ack, m1_ack;
  logic [AW-1:0] sram_waddr, sram_raddr;
  logic [7:0]    sram_wdata, sram_rdata;
  logic          sram_wen, busy;

  always #5 clk = ~clk;

  subservient_sram_arb #(.memsize(MEMSIZE)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_wb_m0_adr(m0_adr), .i_wb_m0_dat(m0_dat), .i_wb_m0_sel(m0_sel),
    .i_wb_m0_we(m0_we), .i_wb_m0_stb(m0_stb),
    .o_wb_m0_rdt(m0_rdt), .o_wb_m0_ack(m0_ack),
    .i_wb_m1_adr(m1_adr), .i_wb_m1_dat(m1_dat), .i_wb_m1_sel(m1_sel),
    .i_wb_m1_we(m1_we), .i_wb_m1_stb(m1_stb),
    .o_wb_m1_rdt(m1_rdt), .o_wb_m1_ack(m1_ack),
    .o_sram_waddr(sram_waddr), .o_sram_wdata(sram_wdata), .o_sram_wen(sram_wen),
    .o_sram_raddr(sram_raddr), .i_sram_rdata(sram_rdata), .o_busy(busy)
  );

  function automatic logic [7:0] init_byte(int i);
    return 8'((i * 37) + 5);
  endfunction

  // SRAM macro model: registered read, one cycle latency.
  logic [7:0] sram [MEMSIZE];
  bit         sram_loaded = 1'b0;
  always @(posedge clk) begin
    if (!sram_loaded) begin
      for (int i = 0; i < MEMSIZE; i++) sram[i] <= init_byte(i);
      sram_loaded <= 1'b1;
    end else if (sram_wen) begin
      sram[sram_waddr] <= sram_wdata;
    end
    sram_rdata <= sram[sram_raddr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [31:0] adr; logic [31:0] dat; logic [3:0] sel; bit we; } txn_t;
  typedef struct { int m; bit we; logic [31:0] rdt; int cyc; } exp_t;
  typedef struct { int addr; logic [7:0] data; } wr_t;

  exp_t       exp_q[$];
  wr_t        wr_q[$];
  logic [7:0] model_mem [MEMSIZE];
  int         last_served;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         busy_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Serve one word access in the model: word base is the address modulo the
  // memory size with the low two bits cleared; write ack 4 cycles after the
  // sampling edge, read ack 5 cycles after.
  task automatic model_serve(input int m, input txn_t t, input int sample, output int ack_cyc);
    exp_t e;
    int   base;
    base  = int'(t.adr % 32'(MEMSIZE)) & ~3;
    e.m   = m;
    e.we  = t.we;
    e.rdt = 32'h0;
    if (t.we) begin
      for (int b = 0; b < 4; b++)
        if (t.sel[b]) begin
          model_mem[base + b] = t.dat[8*b +: 8];
          wr_q.push_back('{base + b, t.dat[8*b +: 8]});
        end
      ack_cyc = sample + 4;
    end else begin
      for (int b = 0; b < 4; b++) e.rdt[8*b +: 8] = model_mem[base + b];
      ack_cyc = sample + 5;
    end
    e.cyc = ack_cyc;
    exp_q.push_back(e);
    last_served = m;
  endtask

  // Raise the requested strobes together; each master drops its strobe on the
  // cycle it sees its ack, the other keeps waiting.
  task automatic run_pair(input bit r0, input bit r1, input txn_t t0, input txn_t t1);
    int first, a1, a2;
    bit pend0, pend1;
    @(negedge clk);
    if (r0 && r1) first = (last_served == 0) ? 1 : 0;
    else          first = r0 ? 0 : 1;
    model_serve(first, first ? t1 : t0, cyc + 1, a1);
    if (r0 && r1) model_serve(1 - first, first ? t0 : t1, a1 + 2, a2);
    if (r0) begin m0_adr = t0.adr; m0_dat = t0.dat; m0_sel = t0.sel; m0_we = t0.we; m0_stb = 1'b1; end
    if (r1) begin m1_adr = t1.adr; m1_dat = t1.dat; m1_sel = t1.sel; m1_we = t1.we; m1_stb = 1'b1; end
    pend0 = r0;
    pend1 = r1;
    for (int k = 0; k < 60 && (pend0 || pend1); k++) begin
      @(negedge clk);
      if (pend0 && m0_ack) begin m0_stb = 1'b0; pend0 = 1'b0; end
      if (pend1 && m1_ack) begin m1_stb = 1'b0; pend1 = 1'b0; end
    end
    if (pend0 || pend1) begin
      check("txn_timeout", {62'h0, pend1, pend0}, 64'h0);
      m0_stb = 1'b0;
      m1_stb = 1'b0;
      exp_q.delete();
      wr_q.delete();
    end
  endtask

  function automatic txn_t mk(logic [31:0] adr, logic [31:0] dat, logic [3:0] sel, bit we);
    txn_t t;
    t.adr = adr; t.dat = dat; t.sel = sel; t.we = we;
    return t;
  endfunction

  function automatic txn_t rand_txn();
    return mk($urandom, $urandom, 4'($urandom), 1'($urandom));
  endfunction

  // Monitor: pops expectations whenever the DUT writes a byte or acks.
  exp_t mon_e;
  wr_t  mon_w;
  always @(negedge clk) begin
    if (rst_n) begin
      if (busy) busy_cnt++;
      if (sram_wen) begin
        if (wr_q.size() == 0) check("spurious_wen", {63'h0, sram_wen}, 64'h0);
        else begin
          mon_w = wr_q.pop_front();
          check("wen_addr", 64'(sram_waddr), 64'(mon_w.addr));
          check("wen_data", 64'(sram_wdata), 64'(mon_w.data));
        end
      end
      if (m0_ack || m1_ack) begin
        check("dual_ack", {63'h0, m0_ack & m1_ack}, 64'h0);
        if (exp_q.size() == 0) check("spurious_ack", {62'h0, m1_ack, m0_ack}, 64'h0);
        else begin
          mon_e = exp_q.pop_front();
          check("ack_master", {63'h0, m1_ack}, 64'(mon_e.m));
          check("ack_cycle", 64'(cyc), 64'(mon_e.cyc));
          if (!mon_e.we) check("rd_data", 64'(mon_e.m ? m1_rdt : m0_rdt), 64'(mon_e.rdt));
        end
      end
    end
  end

  txn_t none;
  int   b0;

  initial begin
    for (int i = 0; i < MEMSIZE; i++) model_mem[i] = init_byte(i);
    none = mk(32'h0, 32'h0, 4'h0, 1'b0);
    {m0_adr, m0_dat, m0_sel, m0_we, m0_stb} = '0;
    {m1_adr, m1_dat, m1_sel, m1_we, m1_stb} = '0;
    last_served = 1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_ack", {62'h0, m1_ack, m0_ack}, 64'h0);
    check("rst_wen", {63'h0, sram_wen}, 64'h0);
    check("rst_busy", {63'h0, busy}, 64'h0);
    check("rst_addr", {46'h0, sram_waddr, sram_raddr}, 64'h0);
    check("rst_wdata", 64'(sram_wdata), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Full-word write then readback by master 1, with busy duration.
    b0 = busy_cnt;
    run_pair(0, 1, none, mk(32'h10, 32'hA1B2C3D4, 4'hF, 1'b1));
    @(negedge clk);
    check("busy_write", 64'(busy_cnt - b0), 64'd5);
    b0 = busy_cnt;
    run_pair(0, 1, none, mk(32'h10, 32'h0, 4'h0, 1'b0));
    @(negedge clk);
    check("busy_read", 64'(busy_cnt - b0), 64'd6);

    // Contention: m0 writes, m1 reads; grants alternate.
    run_pair(1, 1, mk(32'h40, 32'hCAFEF00D, 4'hF, 1'b1), mk(32'h10, 32'h0, 4'h0, 1'b0));
    run_pair(1, 1, mk(32'h44, 32'h01234567, 4'hF, 1'b1), mk(32'h40, 32'h0, 4'h0, 1'b0));

    // Partial byte enables, aliasing and an all-disabled write.
    run_pair(1, 0, mk(32'h20, 32'h11223344, 4'b0101, 1'b1), none);
    run_pair(1, 0, mk(32'h20, 32'h0, 4'hF, 1'b0), none);
    run_pair(0, 1, mk(32'h0, 32'h0, 4'h0, 1'b0), mk(32'(MEMSIZE + 4), 32'h5A6B7C8D, 4'hF, 1'b1));
    run_pair(1, 0, mk(32'h4, 32'h0, 4'h0, 1'b0), none);
    run_pair(1, 0, mk(32'h31, 32'hFFFFFFFF, 4'h0, 1'b1), none);
    run_pair(0, 1, none, mk(32'h33, 32'h0, 4'h0, 1'b0));

    // Reset while master 1 read is at byte count 2.
    @(negedge clk);
    m1_adr = 32'h10; m1_we = 1'b0; m1_stb = 1'b1;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_ack", {62'h0, m1_ack, m0_ack}, 64'h0);
    check("abort_rdt", {m1_rdt, m0_rdt}, 64'h0);
    check("abort_wen", {63'h0, sram_wen}, 64'h0);
    check("abort_busy", {63'h0, busy}, 64'h0);
    check("abort_addr", {46'h0, sram_waddr, sram_raddr}, 64'h0);
    m1_stb = 1'b0;
    exp_q.delete();
    wr_q.delete();
    last_served = 1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("idle_after_rst", {63'h0, busy}, 64'h0);
    run_pair(1, 1, mk(32'h10, 32'h0, 4'h0, 1'b0), mk(32'h14, 32'h0, 4'h0, 1'b0));

    for (int n = 0; n < 40; n++) begin
      int r;
      r = int'($urandom_range(1, 3));
      run_pair(r[0], r[1], rand_txn(), rand_txn());
    end

    repeat (4) @(negedge clk);
    check("exp_left", 64'(exp_q.size()), 64'h0);
    check("wr_left", 64'(wr_q.size()), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
